// File: rtl/descrambler_lock_pipe.sv
// Self-synchronising frame descrambler with header-based lock FSM and saturating header-error counter.
// One frame per cycle, 1-cycle registered latency, no backpressure; invalid cycles hold all state.
module descrambler_lock_pipe #(
    parameter int             W           = 30,
    parameter logic [W-1:0]   TAPS        = 30'h0001_8003,
    parameter logic [W-1:0]   RESET_STATE = 30'h2AAA_AAAA,
    parameter int             HDR_W       = 4,
    parameter logic [HDR_W-1:0] HDR_PATTERN = 4'hA,
    parameter int             LOCK_GOOD   = 8,
    parameter int             UNLOCK_BAD  = 4,
    parameter int             ERR_CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [W-1:0]         frameIn,
    input  logic                 frameValid,
    input  logic                 deScrambleEnable,
    input  logic                 clearErr,
    output logic [W-1:0]         dataOut,
    output logic                 dataOutValid,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] headerErrCount
);

    localparam int GCW = $clog2(LOCK_GOOD + 1);
    localparam int BCW = $clog2(UNLOCK_BAD + 1);

    typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    logic [W-1:0]         history_q;
    logic [W-1:0]         data_q;
    logic                 vld_q;
    state_t               state_q, state_d;
    logic [GCW-1:0]       good_q, good_d;
    logic [BCW-1:0]       bad_q, bad_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic [2*W-2:0]       hist_win;
    logic [W-1:0]         desc;
    logic                 hdr_chk;
    logic                 hdr_good;

    // The top bit of the current frame can never be a tap source, so the window stops at 2W-2.
    always_comb begin
        hist_win = {frameIn[W-2:0], history_q};
        desc     = frameIn;
        for (int i = 0; i < W; i++) begin
            for (int k = 0; k < W; k++) begin
                if (TAPS[k]) begin
                    desc[i] = desc[i] ^ hist_win[i+k];
                end
            end
        end
    end

    assign hdr_chk  = frameValid && deScrambleEnable;
    assign hdr_good = (desc[W-1 -: HDR_W] == HDR_PATTERN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            history_q <= RESET_STATE;
            data_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            vld_q <= frameValid;
            if (frameValid) begin
                data_q <= deScrambleEnable ? desc : frameIn;
                if (deScrambleEnable) begin
                    history_q <= frameIn;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            good_q  <= '0;
            bad_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = err_q;
        if (hdr_chk) begin
            case (state_q)
                HUNT: begin
                    if (hdr_good) begin
                        if (good_q == GCW'(LOCK_GOOD - 1)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GCW'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (!hdr_good) begin
                        if (bad_q == BCW'(UNLOCK_BAD - 1)) begin
                            state_d = HUNT;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + BCW'(1);
                        end
                        if (err_q != {ERR_CNT_W{1'b1}}) begin
                            err_d = err_q + ERR_CNT_W'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        // A clear in the same cycle as a bad header leaves the count at zero.
        if (clearErr) begin
            err_d = '0;
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    assign dataOut        = data_q;
    assign dataOutValid   = vld_q;
    assign headerErrCount = err_q;

endmodule
